i2c_slave_receiver: RTL

- I2C target (slave) that receives write transfers from an I2C master: the receiving end of the master's bit/byte transmit path.
- Samples SCL/SDA from the pins and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs the address and each data byte, and delivers received bytes on a valid/ready interface.
- Sits between the open-drain pad logic and a byte consumer (register file or display logic).

---
 rtl/i2c_slave_receiver.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_receiver.sv
// I2C write-only target: synchronises SCL/SDA, matches ADDRESS, ACKs bytes.
// Optional SCL clock stretching with a valid/ready handshake: I2C_SLAVE_CLOCK_STRETCH_EN.
module i2c_slave_receiver #(
  parameter logic [6:0] ADDRESS     = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       addressed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic scl_s, sda_s;
  logic scl_p_q, sda_p_q;
  logic scl_rise_q, scl_fall_q;
  logic sda_rise_q, sda_fall_q;
  logic scl_hi_q, sda_bit_q;
  logic start_w, stop_w;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       sda_oe_q, sda_oe_d;
  logic       scl_oe_q, scl_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_q, addr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Edge flags are registered so all bus events share one pipeline depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      sda_rise_q <= 1'b0;
      sda_fall_q <= 1'b0;
      scl_hi_q   <= 1'b0;
      sda_bit_q  <= 1'b1;
    end else begin
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
      scl_rise_q <= scl_s & ~scl_p_q;
      scl_fall_q <= ~scl_s & scl_p_q;
      sda_rise_q <= sda_s & ~sda_p_q;
      sda_fall_q <= ~sda_s & sda_p_q;
      scl_hi_q   <= scl_s & scl_p_q;
      sda_bit_q  <= sda_s;
    end
  end

  assign start_w = sda_fall_q & scl_hi_q;
  assign stop_w  = sda_rise_q & scl_hi_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    rx_data_d  = rx_data_q;
    addr_d     = addr_q;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    rx_valid_d = rx_valid_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      scl_oe_d   = 1'b0;
    end
`else
    rx_valid_d = 1'b0;
`endif
    if (stop_w) begin
      state_d    = S_IDLE;
      cnt_d      = 3'd0;
      done_d     = 1'b0;
      sda_oe_d   = 1'b0;
      scl_oe_d   = 1'b0;
      rx_valid_d = 1'b0;
      addr_d     = 1'b0;
    end else if (start_w) begin
      state_d    = S_ADDR;
      cnt_d      = 3'd0;
      done_d     = 1'b0;
      sda_oe_d   = 1'b0;
      scl_oe_d   = 1'b0;
      rx_valid_d = 1'b0;
      addr_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_IGNORE: ;
        S_ADDR, S_DATA: begin
          if (scl_rise_q && !done_q) begin
            shreg_d = {shreg_q[6:0], sda_bit_q};
            cnt_d   = cnt_q + 3'd1;
            done_d  = (cnt_q == 3'd7);
          end else if (scl_fall_q && done_q) begin
            done_d = 1'b0;
            if (state_q == S_DATA) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = S_DATA_ACK;
            end else if (shreg_q[7:1] == ADDRESS && !shreg_q[0]) begin
              sda_oe_d = 1'b1;
              addr_d   = 1'b1;
              state_d  = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (scl_fall_q) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = S_DATA;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
            if (state_q == S_DATA_ACK && rx_valid_d) scl_oe_d = 1'b1;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'h00;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      addr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_q     <= addr_d;
    end
  end

`ifndef I2C_SLAVE_CLOCK_STRETCH_EN
  logic unused_rx_ready;
  assign unused_rx_ready = rx_ready;
`endif

  assign sda_oe    = sda_oe_q;
  assign scl_oe    = scl_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign addressed = addr_q;

endmodule
